// File: rtl/axi_pkg.sv
// Shared encodings for the AXI read-channel slave.
// Burst/resp codes, FSM states and the beat-shift helper.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int BEAT_SHIFT_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic int beat_shift(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/axi_ar_fifo.sv
// Generic synchronous FIFO, async active-low reset.
// Head entry is presented combinationally on rd_data.
module axi_ar_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr] <= wr_data;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_read_slave.sv
// AXI4 read slave: AR FIFO, per-beat SRAM read, R response.
// Define AXI_RSLV_UNALIGN_CHK_EN to flag unaligned ARADDR as SLVERR.
module axi_read_slave
    import axi_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int AR_DEPTH   = 4,
    parameter int MEM_AW     = ADDR_WIDTH - 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   ARID,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [7:0]            ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic [1:0]            ARBURST,
    input  logic [3:0]            ARREGION,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [ID_WIDTH-1:0]   RID,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic                  mem_rd_en,
    output logic [MEM_AW-1:0]     mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    localparam int SHIFT = beat_shift(DATA_WIDTH);
    localparam int EW    = ID_WIDTH + ADDR_WIDTH + 13;
    localparam int CW    = $clog2(AR_DEPTH) + 1;
    localparam int AP    = 13;
    localparam int IP    = 13 + ADDR_WIDTH;

    logic [EW-1:0]         ar_in;
    logic [EW-1:0]         head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic                  push;
    logic                  pop;

    logic [ID_WIDTH-1:0]   h_id;
    logic [ADDR_WIDTH-1:0] h_addr;
    logic [7:0]            h_len;
    logic [2:0]            h_size;
    logic [1:0]            h_burst;

    state_t                state;
    state_t                state_nx;
    logic [7:0]            beat_cnt;
    logic [7:0]            beat_nx;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] addr_nx;
    logic [ADDR_WIDTH-1:0] eff_addr;
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  err;
    logic                  last;
    logic                  in_resp;
    logic                  fresh;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  unused_region;

    assign unused_region = ^ARREGION;

    assign ar_in = {ARID, ARADDR, ARLEN, ARSIZE, ARBURST};
    assign push  = ARVALID & ARREADY;
    assign ARREADY = ~fifo_full;

    axi_ar_fifo #(
        .WIDTH (EW),
        .DEPTH (AR_DEPTH)
    ) u_ar_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (ar_in),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign h_burst = head[1:0];
    assign h_size  = head[4:2];
    assign h_len   = head[12:5];
    assign h_addr  = head[AP +: ADDR_WIDTH];
    assign h_id    = head[IP +: ID_WIDTH];

    // Head stays in the FIFO for the whole burst, so its
    // fields act as the burst's working copy.
    always_comb begin
        err = (h_burst != BURST_FIXED) && (h_burst != BURST_INCR);
        if (int'(h_size) > SHIFT) begin
            err = 1'b1;
        end
`ifdef AXI_RSLV_UNALIGN_CHK_EN
        if ((h_addr & (step - 1'b1)) != '0) begin
            err = 1'b1;
        end
`endif
    end

    assign step     = ADDR_WIDTH'(1) << h_size;
    assign eff_addr = (beat_cnt == 8'd0) ? h_addr : cur_addr;

    always_comb begin
        next_addr = eff_addr;
        if (h_burst == BURST_INCR) begin
            next_addr = (eff_addr + step) & ~(step - 1'b1);
        end
    end

    assign in_resp = (state == ST_RESP);
    assign last    = (beat_cnt == h_len);

    assign mem_rd_en   = (state == ST_RD) & ~err;
    assign mem_rd_addr = MEM_AW'(eff_addr >> SHIFT);

    assign RVALID = in_resp;
    assign RLAST  = in_resp & last;
    assign RID    = in_resp ? h_id : '0;
    assign RRESP  = (in_resp & err) ? RESP_SLVERR : RESP_OKAY;

    // SRAM output is only guaranteed for one cycle; hold a copy
    // for the rest of a stalled beat.
    always_comb begin
        RDATA = '0;
        if (in_resp && !err) begin
            RDATA = fresh ? mem_rd_data : rdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            cur_addr <= '0;
            fresh    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state    <= state_nx;
            beat_cnt <= beat_nx;
            cur_addr <= addr_nx;
            fresh    <= (state == ST_RD);
            if (fresh) begin
                rdata_q <= mem_rd_data;
            end
        end
    end

    always_comb begin
        state_nx = state;
        beat_nx  = beat_cnt;
        addr_nx  = cur_addr;
        pop      = 1'b0;
        unique case (1'b1)
            (state == ST_IDLE): begin
                if (!fifo_empty) begin
                    state_nx = ST_RD;
                    beat_nx  = '0;
                end
            end
            (state == ST_RD): begin
                state_nx = ST_RESP;
            end
            (state == ST_RESP): begin
                if (RREADY) begin
                    if (last) begin
                        pop     = 1'b1;
                        beat_nx = '0;
                        state_nx = (fifo_count > CW'(1)) ?
                                   ST_RD : ST_IDLE;
                    end else begin
                        beat_nx  = beat_cnt + 8'd1;
                        addr_nx  = next_addr;
                        state_nx = ST_RD;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_read_slave.sv
// Scoreboard bench for axi_read_slave.
// Expected R beats and SRAM addresses are queued; a monitor compares.
module tb_axi_read_slave;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ARID;
    logic [9:0]  ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic [3:0]  ARREGION;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        mem_rd_en;
    logic [6:0]  mem_rd_addr;
    logic [63:0] mem_rd_data = '0;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t      exp_r[$];
    logic [6:0] exp_m[$];
    beat_t      eb;
    logic [6:0] ea;
    int         checks = 0;
    int         errors = 0;
    int         mem_cnt = 0;
    int         m0;

    axi_read_slave dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ARID        (ARID),
        .ARADDR      (ARADDR),
        .ARLEN       (ARLEN),
        .ARSIZE      (ARSIZE),
        .ARBURST     (ARBURST),
        .ARREGION    (ARREGION),
        .ARVALID     (ARVALID),
        .ARREADY     (ARREADY),
        .RID         (RID),
        .RDATA       (RDATA),
        .RRESP       (RRESP),
        .RLAST       (RLAST),
        .RVALID      (RVALID),
        .RREADY      (RREADY),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mdata(input logic [6:0] a);
        return {16'hC0DE, 41'h0, a};
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mdata(mem_rd_addr);
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd_en) begin
                mem_cnt++;
                if (exp_m.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_unexp: got addr %h expected none",
                             mem_rd_addr);
                end else begin
                    ea = exp_m.pop_front();
                    chk("mem_rd_addr", 64'(mem_rd_addr), 64'(ea));
                end
            end
            if (RVALID && RREADY) begin
                if (exp_r.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL r_unexp: got RID %h expected none", RID);
                end else begin
                    eb = exp_r.pop_front();
                    chk("RID", 64'(RID), 64'(eb.id));
                    chk("RDATA", RDATA, eb.data);
                    chk("RRESP", 64'(RRESP), 64'(eb.resp));
                    chk("RLAST", 64'(RLAST), 64'(eb.last));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xb(input logic [3:0] id, input logic [63:0] d,
                      input logic [1:0] r, input logic l);
        beat_t b;
        b.id = id;
        b.data = d;
        b.resp = r;
        b.last = l;
        exp_r.push_back(b);
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [9:0] a,
                           input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] bt);
        logic ok;
        ok = 1'b0;
        ARID = id;
        ARADDR = a;
        ARLEN = len;
        ARSIZE = sz;
        ARBURST = bt;
        ARVALID = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            ok = ARREADY;
            tick();
            if (ok) break;
        end
        ARVALID = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL ar_timeout: got no ARREADY expected 1");
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 2000; i++) begin
            if (exp_r.size() == 0 && exp_m.size() == 0) break;
            tick();
        end
        chk({name, "_r_left"}, 64'(exp_r.size()), 64'd0);
        chk({name, "_m_left"}, 64'(exp_m.size()), 64'd0);
    endtask

    task automatic wait_rvalid(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (RVALID) break;
        end
        chk(name, 64'(RVALID), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        ARID = '0;
        ARADDR = '0;
        ARLEN = '0;
        ARSIZE = '0;
        ARBURST = '0;
        ARREGION = 4'hA;
        ARVALID = 1'b0;
        RREADY = 1'b1;
        repeat (3) tick();
        chk("rst_RVALID", 64'(RVALID), 64'd0);
        chk("rst_RLAST", 64'(RLAST), 64'd0);
        chk("rst_RID", 64'(RID), 64'd0);
        chk("rst_RDATA", RDATA, 64'd0);
        chk("rst_RRESP", 64'(RRESP), 64'd0);
        chk("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_ARREADY", 64'(ARREADY), 64'd1);

        // single INCR burst, with latency probe
        exp_m.push_back(7'h08);
        exp_m.push_back(7'h09);
        exp_m.push_back(7'h0A);
        exp_m.push_back(7'h0B);
        xb(4'd5, mdata(7'h08), RESP_OKAY, 1'b0);
        xb(4'd5, mdata(7'h09), RESP_OKAY, 1'b0);
        xb(4'd5, mdata(7'h0A), RESP_OKAY, 1'b0);
        xb(4'd5, mdata(7'h0B), RESP_OKAY, 1'b1);
        send_ar(4'd5, 10'h040, 8'd3, 3'd3, BURST_INCR);
        @(negedge clk);
        chk("lat_idle_rvalid", 64'(RVALID), 64'd0);
        @(negedge clk);
        chk("lat_rd_rvalid", 64'(RVALID), 64'd0);
        chk("lat_rd_en", 64'(mem_rd_en), 64'd1);
        @(negedge clk);
        chk("lat_resp_rvalid", 64'(RVALID), 64'd1);
        tick();
        drain("incr");

        // FIXED burst
        for (int i = 0; i < 3; i++) begin
            exp_m.push_back(7'h20);
            xb(4'd2, mdata(7'h20), RESP_OKAY, i == 2);
        end
        send_ar(4'd2, 10'h100, 8'd2, 3'd3, BURST_FIXED);
        drain("fixed");

        // back-pressure on first beat
        RREADY = 1'b0;
        exp_m.push_back(7'h10);
        exp_m.push_back(7'h11);
        xb(4'd3, mdata(7'h10), RESP_OKAY, 1'b0);
        xb(4'd3, mdata(7'h11), RESP_OKAY, 1'b1);
        send_ar(4'd3, 10'h080, 8'd1, 3'd3, BURST_INCR);
        wait_rvalid("bp_rvalid");
        m0 = mem_cnt;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_rvalid", 64'(RVALID), 64'd1);
            chk("bp_hold_rdata", RDATA, mdata(7'h10));
            chk("bp_hold_rlast", 64'(RLAST), 64'd0);
        end
        chk("bp_no_extra_rd", 64'(mem_cnt - m0), 64'd0);
        tick();
        RREADY = 1'b1;
        drain("bp");

        // FIFO full with RREADY held low
        RREADY = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            exp_m.push_back(7'(k));
            xb(4'(k), mdata(7'(k)), RESP_OKAY, 1'b1);
        end
        for (int k = 1; k <= 4; k++) begin
            send_ar(4'(k), 10'(k * 8), 8'd0, 3'd3, BURST_INCR);
        end
        ARID = 4'd5;
        ARADDR = 10'd40;
        ARLEN = 8'd0;
        ARSIZE = 3'd3;
        ARBURST = BURST_INCR;
        ARVALID = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("full_arready", 64'(ARREADY), 64'd0);
        end
        tick();
        RREADY = 1'b1;
        @(negedge clk);
        chk("full_pre_pop", 64'(ARREADY), 64'd0);
        tick();
        chk("full_arready_rise", 64'(ARREADY), 64'd1);
        tick();
        ARVALID = 1'b0;
        drain("full");

        // WRAP and oversize bursts: SLVERR, no SRAM access
        m0 = mem_cnt;
        xb(4'd6, 64'd0, RESP_SLVERR, 1'b0);
        xb(4'd6, 64'd0, RESP_SLVERR, 1'b1);
        send_ar(4'd6, 10'h000, 8'd1, 3'd3, BURST_WRAP);
        xb(4'd8, 64'd0, RESP_SLVERR, 1'b1);
        send_ar(4'd8, 10'h010, 8'd0, 3'd4, BURST_INCR);
        drain("err");
        chk("err_no_rd", 64'(mem_cnt - m0), 64'd0);

        // unaligned start address
        m0 = mem_cnt;
`ifdef AXI_RSLV_UNALIGN_CHK_EN
        xb(4'd7, 64'd0, RESP_SLVERR, 1'b1);
        send_ar(4'd7, 10'h003, 8'd0, 3'd2, BURST_INCR);
        drain("unal");
        chk("unal_rd_cnt", 64'(mem_cnt - m0), 64'd0);
`else
        exp_m.push_back(7'h00);
        xb(4'd7, mdata(7'h00), RESP_OKAY, 1'b1);
        send_ar(4'd7, 10'h003, 8'd0, 3'd2, BURST_INCR);
        drain("unal");
        chk("unal_rd_cnt", 64'(mem_cnt - m0), 64'd1);
`endif

        // address wrap at top of space
        exp_m.push_back(7'h7F);
        exp_m.push_back(7'h00);
        xb(4'd9, mdata(7'h7F), RESP_OKAY, 1'b0);
        xb(4'd9, mdata(7'h00), RESP_OKAY, 1'b1);
        send_ar(4'd9, 10'h3F8, 8'd1, 3'd3, BURST_INCR);
        drain("wrap");

        // 256-beat burst
        for (int i = 0; i < 256; i++) begin
            exp_m.push_back(7'(i));
            xb(4'd10, mdata(7'(i)), RESP_OKAY, i == 255);
        end
        send_ar(4'd10, 10'h000, 8'd255, 3'd3, BURST_INCR);
        drain("len255");

        // reset in the middle of a burst
        RREADY = 1'b0;
        exp_m.push_back(7'h30);
        send_ar(4'd11, 10'h180, 8'd3, 3'd3, BURST_INCR);
        wait_rvalid("mid_rvalid");
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_RVALID", 64'(RVALID), 64'd0);
        chk("mid_rst_RLAST", 64'(RLAST), 64'd0);
        chk("mid_rst_RID", 64'(RID), 64'd0);
        chk("mid_rst_RDATA", RDATA, 64'd0);
        exp_r.delete();
        exp_m.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ARREADY", 64'(ARREADY), 64'd1);
        RREADY = 1'b1;
        m0 = mem_cnt;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_idle", 64'(RVALID), 64'd0);
        end
        chk("post_rst_no_rd", 64'(mem_cnt - m0), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
